// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter. It sits on the single-cycle core's data bus
// next to the data memory. Stores to the DATA register queue bytes into a
// small TX FIFO. A serializer drains the FIFO as 8N1 frames on the tx pin.
// Loads from the STATUS register return line and FIFO state.
//
// Register map:
//   BASE_ADDR     DATA    write: push datain[7:0]; read: 0
//   BASE_ADDR+4   STATUS  read : {24'b0, count[3:0], overflow, empty, full, busy}
//                         write: datain[3]=1 clears overflow
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   synchronous active-high reset
//   WriteEn  in   1   core store strobe
//   address  in  32   core data address
//   datain   in  32   core store data
//   dataout  out 32   read data for the decoded register, 0 when not selected
//   sel      out  1   combinational hit on DATA or STATUS
//   tx       out  1   serial line, idles high
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WriteEn,
    input  logic [31:0] address,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        sel,
    output logic        tx
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } txState_t;

    // FIFO storage and bookkeeping
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    // Serializer state
    txState_t          r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bitIdx;
    logic [7:0]        r_shift;
    logic              r_tx;

    // Decode and handshake wires
    logic              w_hitData;
    logic              w_hitStatus;
    logic              w_dataWr;
    logic              w_statusWr;
    logic              w_empty;
    logic              w_full;
    logic              w_busy;
    logic              w_baudDone;
    logic              w_pop;
    logic              w_push;
    logic [7:0]        w_head;
    logic [3:0]        w_count4;
    logic [31:0]       w_status;
    logic              w_unusedDatain;

    // Full 32-bit address compare; anything outside the two registers is
    // invisible to this block.
    assign w_hitData   = (address == BASE_ADDR);
    assign w_hitStatus = (address == STATUS_ADDR);
    assign w_dataWr    = WriteEn && w_hitData;
    assign w_statusWr  = WriteEn && w_hitStatus;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_busy     = (r_state != S_IDLE);
    assign w_baudDone = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_head     = r_mem[r_rdPtr];

    // The serializer takes a byte either when it is sitting idle or at the
    // last cycle of a stop bit, which is what lets frames run back-to-back.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baudDone));

    // A store to a full FIFO still fits if the head leaves on the same edge.
    assign w_push = w_dataWr && (!w_full || w_pop);

    assign w_count4 = 4'(r_count);
    assign w_status = {24'd0, w_count4, r_overflow, w_empty, w_full, w_busy};

    // Only the low byte and bit 3 of store data mean anything here.
    assign w_unusedDatain = ^datain[31:8];

    // Combinational read port: STATUS returns the status word, DATA and
    // unmapped addresses return zero. Reads never change state.
    always_comb begin
        dataout = 32'd0;
        sel     = w_hitData || w_hitStatus;
        if (w_hitStatus) begin
            dataout = w_status;
        end
    end

    assign tx = r_tx;

    // FIFO pointers, occupancy and the sticky overflow flag. Pointers are
    // PTR_W bits wide so they wrap on their own for a power-of-two depth.
    // A store that cannot be accepted is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= datain[7:0];
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_dataWr && !w_push) begin
                r_overflow <= 1'b1;
            end else if (w_statusWr && datain[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Frame serializer. Each of START, the eight DATA bits and STOP lasts
    // CLKS_PER_BIT cycles as timed by r_baud. The line value is registered
    // and updated on the same edge as the state change, so tx always
    // matches the state the FSM has just entered. In DATA the next line
    // value is r_shift[1] because the shift happens on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baudDone) begin
                        r_baud   <= '0;
                        r_bitIdx <= '0;
                        r_state  <= S_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baudDone) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Drives mmio_uart_tx through directed scenarios and a randomized phase. It
// compares tx, sel and dataout after every clock edge against a reference
// model. The model keeps the FIFO as a queue. It describes the line as the
// time elapsed since the current frame began: slot 0 is the start bit,
// slots 1..8 are data bits LSB first, and slot 9 is the stop bit.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] STAT   = 32'h0000_1004;
    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam int          FRAME  = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        WriteEn;
    logic [31:0] address;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        sel;
    logic        tx;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    logic [7:0] mQueue [$];
    bit         mActive  = 1'b0;
    int         mElapsed = 0;
    logic [7:0] mByte    = 8'h00;
    bit         mOvf     = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .WriteEn(WriteEn),
        .address(address),
        .datain (datain),
        .dataout(dataout),
        .sel    (sel),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic modelEdge(input logic r, input logic we,
                             input logic [31:0] a, input logic [31:0] d);
        bit pop;
        if (r) begin
            mQueue.delete();
            mOvf     = 1'b0;
            mActive  = 1'b0;
            mElapsed = 0;
            return;
        end
        pop = 1'b0;
        if (!mActive) begin
            pop = (mQueue.size() > 0);
        end else if (mElapsed == FRAME - 1) begin
            if (mQueue.size() > 0) pop = 1'b1;
            else mActive = 1'b0;
        end else begin
            mElapsed++;
        end
        if (pop) begin
            mByte    = mQueue.pop_front();
            mActive  = 1'b1;
            mElapsed = 0;
        end
        if (we && a == BASE) begin
            if (mQueue.size() < DEPTH) mQueue.push_back(d[7:0]);
            else mOvf = 1'b1;
        end
        if (we && a == STAT && d[3]) mOvf = 1'b0;
    endtask

    function automatic logic expTx();
        int slot;
        if (!mActive) return 1'b1;
        slot = mElapsed / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return mByte[slot-1];
    endfunction

    function automatic logic [31:0] expStatus();
        logic [3:0] c;
        c = 4'(mQueue.size());
        return {24'd0, c, mOvf, (mQueue.size() == 0), (mQueue.size() == DEPTH), mActive};
    endfunction

    task automatic checkOutput(input string tag);
        logic        eTx;
        logic        eSel;
        logic [31:0] eData;
        eTx   = expTx();
        eSel  = (address == BASE) || (address == STAT);
        eData = (address == STAT) ? expStatus() : 32'd0;
        checkCount++;
        assert (tx === eTx) passCount++;
        else $error("[TB] FAIL %s tx got %0b expected %0b", tag, tx, eTx);
        checkCount++;
        assert (sel === eSel) passCount++;
        else $error("[TB] FAIL %s sel got %0b expected %0b", tag, sel, eSel);
        checkCount++;
        assert (dataout === eData) passCount++;
        else $error("[TB] FAIL %s dataout got %h expected %h", tag, dataout, eData);
    endtask

    // One clock: drive inputs, take the edge, update the model, check #1 later.
    task automatic applyStimulus(input logic r, input logic we, input logic [31:0] a,
                                 input logic [31:0] d, input string tag);
        reset   = r;
        WriteEn = we;
        address = a;
        datain  = d;
        @(posedge clk);
        modelEdge(r, we, a, d);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, STAT, 32'd0, tag);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((mActive || mQueue.size() > 0) && n < budget) begin
            applyStimulus(1'b0, 1'b0, STAT, 32'd0, tag);
            n++;
        end
        checkCount++;
        assert (!(mActive || mQueue.size() > 0)) passCount++;
        else $error("[TB] FAIL %s drain timeout got busy expected idle within %0d cycles", tag, budget);
    endtask

    initial begin
        int          busyCycles;
        bit          found;
        logic [31:0] a;
        int          r;

        reset   = 1'b1;
        WriteEn = 1'b0;
        address = STAT;
        datain  = 32'd0;

        // Reset with a DATA store asserted: the store must be ignored
        applyStimulus(1'b1, 1'b1, BASE, 32'h5A, "resetWrite");
        applyStimulus(1'b1, 1'b0, BASE, 32'h0, "reset");
        applyStimulus(1'b0, 1'b0, STAT, 32'd0, "statusAfterReset");
        checkCount++;
        assert (dataout === 32'h0000_0004) passCount++;
        else $error("[TB] FAIL resetStatus dataout got %h expected %h", dataout, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0000_2000, 32'd0, "unmapped");

        // Single frame 0xA5 and exact busy length
        applyStimulus(1'b0, 1'b1, BASE, 32'h0000_00A5, "writeA5");
        busyCycles = 0;
        for (int i = 0; i < 45; i++) begin
            applyStimulus(1'b0, 1'b0, STAT, 32'd0, "frameA5");
            if (dataout[0]) busyCycles++;
        end
        checkCount++;
        assert (busyCycles === 40) passCount++;
        else $error("[TB] FAIL busyLength got %0d expected %0d", busyCycles, 40);

        // Five back-to-back stores fill the FIFO; frames run without gaps
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, BASE, 32'(i), "burst5");
        applyStimulus(1'b0, 1'b0, STAT, 32'd0, "burst5Full");
        checkCount++;
        assert (dataout[7:4] === 4'd4 && dataout[3] === 1'b0) passCount++;
        else $error("[TB] FAIL burstCount got %h expected count 4 no overflow", dataout);
        drain(260, "burst5Drain");

        // Overflow while full, then clear via STATUS
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, BASE, 32'($urandom_range(0, 255)), "fill");
        applyStimulus(1'b0, 1'b1, BASE, 32'h77, "write77Dropped");
        applyStimulus(1'b0, 1'b0, STAT, 32'd0, "ovfSet");
        checkCount++;
        assert (dataout[3] === 1'b1) passCount++;
        else $error("[TB] FAIL ovfSet got %0b expected %0b", dataout[3], 1'b1);
        applyStimulus(1'b0, 1'b1, STAT, 32'h8, "ovfClear");
        drain(260, "ovfDrain");

        // Store on the same edge as the end-of-STOP pop while full
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, BASE, 32'($urandom_range(0, 255)), "fill2");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mActive && mElapsed == FRAME - 1 && mQueue.size() == DEPTH) found = 1'b1;
            else idleCycles(1, "waitStopEnd");
        end
        checkCount++;
        assert (found === 1'b1) passCount++;
        else $error("[TB] FAIL waitStopEnd got timeout expected stop end");
        applyStimulus(1'b0, 1'b1, BASE, 32'($urandom_range(0, 255)), "pushOnPop");
        checkCount++;
        assert (dataout === 32'd0 && mQueue.size() == DEPTH) passCount++;
        else $error("[TB] FAIL pushOnPop got %h expected DATA read 0 with full queue", dataout);
        drain(300, "pushOnPopDrain");

        // Reset during DATA bit 3 of 0xFF: line goes quiet
        applyStimulus(1'b0, 1'b1, BASE, 32'hFF, "writeFF");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mActive && mElapsed == 4 * CPB + 1) found = 1'b1;
            else idleCycles(1, "waitBit3");
        end
        checkCount++;
        assert (found === 1'b1) passCount++;
        else $error("[TB] FAIL waitBit3 got timeout expected bit 3");
        applyStimulus(1'b1, 1'b1, BASE, 32'h33, "midFrameReset");
        idleCycles(100, "quietAfterReset");

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                applyStimulus(1'b1, 1'b0, STAT, 32'd0, "rndReset");
            end else if (r < 18) begin
                applyStimulus(1'b0, 1'b1, BASE, $urandom, "rndData");
            end else if (r < 24) begin
                applyStimulus(1'b0, 1'b1, STAT, $urandom, "rndStatusWr");
            end else if (r < 30) begin
                a = $urandom | 32'h8000_0000;
                applyStimulus(1'b0, 1'b1, a, $urandom, "rndOtherWr");
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = BASE;
                    1:       a = STAT;
                    default: a = $urandom | 32'h8000_0000;
                endcase
                applyStimulus(1'b0, 1'b0, a, 32'd0, "rndRead");
            end
        end
        drain(300, "rndDrain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
